// File: rtl/pc_fetch_sequencer.sv
// Program-counter owner and instruction-fetch sequencer: fetches over a req/ack
// memory port with a timeout guard and hands instructions to decode via valid/ready.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_ADDR     = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_add,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        stall,
  input  logic        halt_in,
  output logic        halted,
  output logic        imem_err,
  output logic        misalign_err,
  output logic [31:0] instr_count
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [31:0] RESET_PC = {RESET_ADDR[31:2], 2'b00};
  localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_REQ    = 2'd0,
    S_ISSUE  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] tmo_cnt, tmo_cnt_nxt;
  logic [31:0]      pc_nxt, instr_nxt, count_nxt;
  logic             valid_nxt, halted_nxt, err_nxt, misalign_nxt;
  logic             accept;
  logic [CNT_W-1:0] tmo_inc;

  // State and architectural registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_REQ;
      pc           <= RESET_PC;
      instr        <= 32'h0;
      instr_valid  <= 1'b0;
      halted       <= 1'b0;
      imem_err     <= 1'b0;
      misalign_err <= 1'b0;
      instr_count  <= 32'h0;
      tmo_cnt      <= '0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      instr        <= instr_nxt;
      instr_valid  <= valid_nxt;
      halted       <= halted_nxt;
      imem_err     <= err_nxt;
      misalign_err <= misalign_nxt;
      instr_count  <= count_nxt;
      tmo_cnt      <= tmo_cnt_nxt;
    end
  end

  assign accept  = instr_valid & instr_ready & ~stall;
  assign tmo_inc = tmo_cnt + CNT_W'(1);

  // Next-state and next-register values; everything holds unless a state acts
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    instr_nxt    = instr;
    valid_nxt    = instr_valid;
    halted_nxt   = halted;
    err_nxt      = imem_err;
    misalign_nxt = 1'b0;
    count_nxt    = instr_count;
    tmo_cnt_nxt  = tmo_cnt;

    case (state)
      S_REQ: begin
        if (imem_ack) begin
          instr_nxt   = imem_rdata;
          valid_nxt   = 1'b1;
          tmo_cnt_nxt = '0;
          state_nxt   = S_ISSUE;
        end else begin
          tmo_cnt_nxt = tmo_inc;
          if (tmo_inc >= TIMEOUT_LIMIT) begin
            err_nxt    = 1'b1;
            halted_nxt = 1'b1;
            state_nxt  = S_HALTED;
          end
        end
      end

      S_ISSUE: begin
        if (accept) begin
          valid_nxt = 1'b0;
          if (instr_count != COUNT_MAX) begin
            count_nxt = instr_count + 32'd1;
          end
          if (halt_in) begin
            halted_nxt = 1'b1;
            state_nxt  = S_HALTED;
          end else begin
            // Misaligned targets are still forced to a word boundary
            pc_nxt       = {next_addr[31:2], 2'b00};
            misalign_nxt = |next_addr[1:0];
            state_nxt    = S_REQ;
          end
        end
      end

      S_HALTED: begin
        valid_nxt  = 1'b0;
        halted_nxt = 1'b1;
      end

      default: begin
        state_nxt = S_REQ;
      end
    endcase
  end

  assign imem_req  = (state == S_REQ);
  assign imem_addr = pc;
  assign pc_add    = pc + 32'd4;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: directed plan steps plus randomized
// fetch/issue traffic checked against an architectural reference model.
module tb_pc_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic [31:0] next_addr;
  logic [31:0] pc;
  logic [31:0] pc_add;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        stall;
  logic        halt_in;
  logic        halted;
  logic        imem_err;
  logic        misalign_err;
  logic [31:0] instr_count;

  int checks;
  int failures;

  // Reference model of architectural state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_count;
  logic        m_halted;
  logic        m_mis;

  pc_fetch_sequencer #(
    .RESET_ADDR    (32'h0000_0000),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .next_addr   (next_addr),
    .pc          (pc),
    .pc_add      (pc_add),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .stall       (stall),
    .halt_in     (halt_in),
    .halted      (halted),
    .imem_err    (imem_err),
    .misalign_err(misalign_err),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // REQ phase: wait `delay` cycles without ack, then ack with `rdata`
  task automatic do_fetch(input int delay, input logic [31:0] rdata);
    for (int i = 0; i < delay; i++) begin
      imem_ack    = 1'b0;
      imem_rdata  = $urandom;
      instr_ready = 1'($urandom);
      check1("req_wait", imem_req, 1'b1);
      check32("req_addr_wait", imem_addr, m_pc);
      tick();
      check1("misalign_drop", misalign_err, 1'b0);
    end
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    check1("req_ack", imem_req, 1'b1);
    check32("req_addr_ack", imem_addr, m_pc);
    tick();
    imem_ack = 1'b0;
    m_instr  = rdata;
    check1("misalign_drop", misalign_err, 1'b0);
    check1("issue_valid", instr_valid, 1'b1);
    check32("issue_instr", instr, m_instr);
    check1("issue_noreq", imem_req, 1'b0);
  endtask

  // ISSUE phase: `hold` non-accepting cycles, then one accept
  task automatic do_issue(input int hold, input logic [31:0] na, input logic hlt);
    for (int i = 0; i < hold; i++) begin
      instr_ready = 1'($urandom);
      stall       = instr_ready ? 1'b1 : 1'($urandom);
      halt_in     = 1'($urandom);
      imem_ack    = 1'($urandom);
      next_addr   = na;
      tick();
      check32("hold_pc", pc, m_pc);
      check1("hold_valid", instr_valid, 1'b1);
      check32("hold_instr", instr, m_instr);
      check32("hold_count", instr_count, m_count);
    end
    stall       = 1'b0;
    instr_ready = 1'b1;
    halt_in     = hlt;
    imem_ack    = 1'($urandom);
    next_addr   = na;
    tick();
    instr_ready = 1'b0;
    halt_in     = 1'b0;
    imem_ack    = 1'b0;
    m_count = (m_count == 32'hFFFF_FFFF) ? m_count : m_count + 32'd1;
    if (hlt) begin
      m_halted = 1'b1;
      m_mis    = 1'b0;
    end else begin
      m_pc  = na & ~32'd3;
      m_mis = (na[1:0] != 2'b00);
    end
    check32("acc_pc", pc, m_pc);
    check32("acc_pc_add", pc_add, m_pc + 32'd4);
    check1("acc_valid", instr_valid, 1'b0);
    check1("acc_halted", halted, m_halted);
    check1("acc_misalign", misalign_err, m_mis);
    check32("acc_count", instr_count, m_count);
    check1("acc_req", imem_req, ~m_halted);
    if (!m_halted) check32("acc_addr", imem_addr, m_pc);
  endtask

  task automatic model_reset();
    m_pc     = 32'h0;
    m_instr  = 32'h0;
    m_count  = 32'h0;
    m_halted = 1'b0;
    m_mis    = 1'b0;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    next_addr   = 32'h0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    instr_ready = 1'b0;
    stall       = 1'b0;
    halt_in     = 1'b0;
    model_reset();

    // Reset state
    #3;
    check32("rst_pc", pc, 32'h0);
    check32("rst_instr", instr, 32'h0);
    check1("rst_valid", instr_valid, 1'b0);
    check1("rst_halted", halted, 1'b0);
    check1("rst_err", imem_err, 1'b0);
    check1("rst_mis", misalign_err, 1'b0);
    check32("rst_count", instr_count, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    check32("rst_pc_add", pc_add, 32'h4);

    // First instruction with same-cycle ack, sequential next
    do_fetch(0, 32'h1234_5678);
    do_issue(0, m_pc + 32'd4, 1'b0);
    check32("first_pc", pc, 32'h4);

    // Branch held off by stall for 3 cycles
    do_fetch(1, $urandom);
    for (int i = 0; i < 3; i++) begin
      stall       = 1'b1;
      instr_ready = 1'b1;
      next_addr   = 32'h0000_0100;
      tick();
      check32("stall_pc", pc, 32'h4);
      check1("stall_valid", instr_valid, 1'b1);
    end
    do_issue(0, 32'h0000_0100, 1'b0);

    // Misaligned target
    do_fetch(0, $urandom);
    do_issue(0, 32'h0000_0102, 1'b0);
    check32("mis_pc", pc, 32'h0000_0100);

    // Randomized traffic
    for (int n = 0; n < 24; n++) begin
      do_fetch(int'($urandom_range(0, 2)), $urandom);
      do_issue(int'($urandom_range(0, 3)), $urandom, 1'b0);
    end

    // PC wrap at the top of the address space
    do_fetch(0, $urandom);
    do_issue(1, 32'hFFFF_FFFC, 1'b0);
    check32("wrap_pc_add", pc_add, 32'h0);
    do_fetch(0, $urandom);
    do_issue(0, pc_add, 1'b0);
    check32("wrap_pc", pc, 32'h0);

    // Halt at pc 0x8
    do_fetch(0, $urandom);
    do_issue(0, 32'h8, 1'b0);
    do_fetch(1, $urandom);
    do_issue(2, $urandom, 1'b1);
    for (int i = 0; i < 4; i++) begin
      imem_ack    = 1'b1;
      instr_ready = 1'b1;
      next_addr   = $urandom;
      tick();
      check32("halt_pc", pc, 32'h8);
      check1("halt_req", imem_req, 1'b0);
      check1("halt_valid", instr_valid, 1'b0);
      check1("halt_sticky", halted, 1'b1);
      check32("halt_count", instr_count, m_count);
    end
    imem_ack    = 1'b0;
    instr_ready = 1'b0;

    // Asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check32("arst_pc", pc, 32'h0);
    check1("arst_halted", halted, 1'b0);
    check32("arst_count", instr_count, 32'h0);
    tick();
    rst_n = 1'b1;

    // Fetch timeout with no ack ever
    for (int i = 0; i < 4; i++) begin
      check1("tmo_req", imem_req, 1'b1);
      check1("tmo_err_pre", imem_err, 1'b0);
      tick();
    end
    check1("tmo_err", imem_err, 1'b1);
    check1("tmo_halted", halted, 1'b1);
    check1("tmo_req_off", imem_req, 1'b0);
    for (int i = 0; i < 3; i++) begin
      imem_ack   = 1'b1;
      imem_rdata = $urandom;
      tick();
      check1("tmo_late_ack_valid", instr_valid, 1'b0);
      check1("tmo_late_ack_err", imem_err, 1'b1);
      check32("tmo_late_ack_pc", pc, 32'h0);
    end
    imem_ack = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
